// File: rtl/vend_state_ctrl_if.sv
// vend_state_ctrl_if: bundle between the touch front end and the vending FSM.
// master = touch front end (keys, credit), slave = vend_state_ctrl.
interface vend_state_ctrl_if;
  logic        select_flag;
  logic        sure_flag;
  logic        cancel_flag;
  logic        charge_flag;
  logic        coin_sig;
  logic        coin_ov_flag;
  logic        nonenough_flag;
  logic [3:0]  product_number;
  logic [10:0] coin_val_sum;
  logic        selected_sta_flag;
  logic        coin_sta_flag;
  logic        pay_sta_flag;
  logic        coin_fn_flag;
  logic        pay_st_flag;
  logic        charge_st_flag;
  logic        coin_ov_err;
  logic        pay_fail;
  logic        timeout_pulse;
  logic        dispense_busy;
  logic [3:0]  dispense_product;
  logic [10:0] charge_val;
  logic [2:0]  state;

  modport master (
    output select_flag, sure_flag, cancel_flag,
    output charge_flag, coin_sig,
    output coin_ov_flag, nonenough_flag,
    output product_number, coin_val_sum,
    input  selected_sta_flag, coin_sta_flag,
    input  pay_sta_flag, coin_fn_flag,
    input  pay_st_flag, charge_st_flag,
    input  coin_ov_err, pay_fail, timeout_pulse,
    input  dispense_busy, dispense_product,
    input  charge_val, state
  );

  modport slave (
    input  select_flag, sure_flag, cancel_flag,
    input  charge_flag, coin_sig,
    input  coin_ov_flag, nonenough_flag,
    input  product_number, coin_val_sum,
    output selected_sta_flag, coin_sta_flag,
    output pay_sta_flag, coin_fn_flag,
    output pay_st_flag, charge_st_flag,
    output coin_ov_err, pay_fail, timeout_pulse,
    output dispense_busy, dispense_product,
    output charge_val, state
  );
endinterface

// File: rtl/vend_state_ctrl.sv
// vend_state_ctrl: Moore FSM sequencing coin entry, payment, dispense, refund.
// Ports: clk, rst (sync, active-high), bus (vend_state_ctrl_if.slave).
// Optional: define VEND_TIMEOUT_EN for the SELECT inactivity timeout.
module vend_state_ctrl #(
  parameter int unsigned DISP_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  vend_state_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    COIN_CHK = 3'd2,
    COIN_ACK = 3'd3,
    PAY_CHK  = 3'd4,
    PAY_EXE  = 3'd5,
    DISPENSE = 3'd6,
    CHARGE   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [7:0]  disp_q, disp_d;
  logic [3:0]  prod_q, prod_d;
  logic [10:0] chg_q, chg_d;
  logic        ov_q, ov_d;
  logic        fail_q, fail_d;
  logic        to_q, to_d;
  logic        to_hit;

`ifdef VEND_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        act;

  assign act = bus.select_flag | bus.sure_flag |
               bus.cancel_flag | bus.coin_sig;
  assign to_hit = (state_q == SELECT) && !act &&
                  (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Counts idle SELECT cycles; any key touch restarts it.
  always_ff @(posedge clk) begin
    if (rst || state_q != SELECT || act || to_hit)
      to_cnt_q <= '0;
    else
      to_cnt_q <= to_cnt_q + 32'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    disp_d  = disp_q;
    prod_d  = prod_q;
    chg_d   = chg_q;
    ov_d    = 1'b0;
    fail_d  = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.charge_flag &&
            bus.coin_val_sum != 11'd0) begin
          state_d = CHARGE;
          chg_d   = bus.coin_val_sum;
        end else if (bus.coin_sig) begin
          state_d = COIN_CHK;
          ret_d   = IDLE;
        end else if (bus.select_flag) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (bus.cancel_flag) begin
          state_d = IDLE;
        end else if (bus.sure_flag &&
                     bus.product_number != 4'd0) begin
          state_d = PAY_CHK;
        end else if (bus.coin_sig) begin
          state_d = COIN_CHK;
          ret_d   = SELECT;
        end else if (to_hit) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end
      end
      COIN_CHK: begin
        if (bus.coin_ov_flag) begin
          state_d = ret_q;
          ov_d    = 1'b1;
        end else begin
          state_d = COIN_ACK;
        end
      end
      COIN_ACK: state_d = ret_q;
      PAY_CHK: begin
        if (bus.nonenough_flag) begin
          state_d = SELECT;
          fail_d  = 1'b1;
        end else begin
          state_d = PAY_EXE;
          prod_d  = bus.product_number;
        end
      end
      PAY_EXE: begin
        state_d = DISPENSE;
        disp_d  = 8'(DISP_CYCLES - 1);
      end
      DISPENSE: begin
        if (disp_q == 8'd0)
          state_d = IDLE;
        else
          disp_d = disp_q - 8'd1;
      end
      CHARGE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      disp_q  <= '0;
      prod_q  <= '0;
      chg_q   <= '0;
      ov_q    <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      disp_q  <= disp_d;
      prod_q  <= prod_d;
      chg_q   <= chg_d;
      ov_q    <= ov_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

  assign bus.state             = state_q;
  assign bus.selected_sta_flag = (state_q == SELECT);
  assign bus.coin_sta_flag     = (state_q == COIN_CHK) ||
                                 (state_q == COIN_ACK);
  assign bus.pay_sta_flag      = (state_q == PAY_CHK) ||
                                 (state_q == PAY_EXE);
  assign bus.coin_fn_flag      = (state_q == COIN_ACK);
  assign bus.pay_st_flag       = (state_q == PAY_EXE);
  assign bus.charge_st_flag    = (state_q == CHARGE);
  assign bus.dispense_busy     = (state_q == DISPENSE);
  assign bus.dispense_product  = prod_q;
  assign bus.charge_val        = chg_q;
  assign bus.coin_ov_err       = ov_q;
  assign bus.pay_fail          = fail_q;
  assign bus.timeout_pulse     = to_q;

endmodule

// File: tb/tb_vend_state_ctrl.sv
// tb_vend_state_ctrl: scoreboard bench for vend_state_ctrl.
// Expected per-cycle snapshots are queued at drive time, popped after each edge.
module tb_vend_state_ctrl;

  logic clk;
  logic rst;

  vend_state_ctrl_if vif ();

  vend_state_ctrl #(
    .DISP_CYCLES    (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [2:0]  ev;
    logic [3:0]  prod;
    logic [10:0] chg;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  logic        p_rst;
  logic        p_ov;
  logic        p_ne;
  logic [3:0]  p_prod;
  logic [10:0] p_sum;
  logic [3:0]  e_prod;
  logic [10:0] e_chg;

  localparam logic [4:0] T_SEL = 5'b10000;
  localparam logic [4:0] T_SURE = 5'b01000;
  localparam logic [4:0] T_CAN = 5'b00100;
  localparam logic [4:0] T_CHG = 5'b00010;
  localparam logic [4:0] T_COIN = 5'b00001;
  localparam logic [2:0] E_OV = 3'b100;
  localparam logic [2:0] E_FAIL = 3'b010;
  localparam logic [2:0] E_TO = 3'b001;

  task automatic chk(input string tag, input int got,
                     input int expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc, got, expv);
    end
  endtask

  // One cycle of stimulus; es/ev is what must show after the next edge.
  task automatic step(input logic [4:0] t,
                      input logic [2:0] es,
                      input logic [2:0] ev);
    @(negedge clk);
    rst                = p_rst;
    vif.select_flag    = t[4];
    vif.sure_flag      = t[3];
    vif.cancel_flag    = t[2];
    vif.charge_flag    = t[1];
    vif.coin_sig       = t[0];
    vif.coin_ov_flag   = p_ov;
    vif.nonenough_flag = p_ne;
    vif.product_number = p_prod;
    vif.coin_val_sum   = p_sum;
    sb_q.push_back('{st: es, ev: ev,
                     prod: e_prod, chg: e_chg});
  endtask

  task automatic idle(input int n, input logic [2:0] es);
    for (int i = 0; i < n; i++)
      step(5'b0, es, 3'b0);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      chk("state", int'(vif.state), int'(m_e.st));
      chk("phase",
          int'({vif.selected_sta_flag,
                vif.coin_sta_flag,
                vif.pay_sta_flag}),
          int'({m_e.st == 3'd1,
                m_e.st == 3'd2 || m_e.st == 3'd3,
                m_e.st == 3'd4 || m_e.st == 3'd5}));
      chk("strobe",
          int'({vif.coin_fn_flag,
                vif.pay_st_flag,
                vif.charge_st_flag}),
          int'({m_e.st == 3'd3,
                m_e.st == 3'd5,
                m_e.st == 3'd7}));
      chk("busy", int'(vif.dispense_busy),
          int'(m_e.st == 3'd6));
      chk("event",
          int'({vif.coin_ov_err,
                vif.pay_fail,
                vif.timeout_pulse}),
          int'(m_e.ev));
      chk("prod", int'(vif.dispense_product),
          int'(m_e.prod));
      chk("chgval", int'(vif.charge_val),
          int'(m_e.chg));
    end
  end

  initial begin
    rst                = 1'b1;
    vif.select_flag    = 1'b0;
    vif.sure_flag      = 1'b0;
    vif.cancel_flag    = 1'b0;
    vif.charge_flag    = 1'b0;
    vif.coin_sig       = 1'b0;
    vif.coin_ov_flag   = 1'b0;
    vif.nonenough_flag = 1'b0;
    vif.product_number = 4'd0;
    vif.coin_val_sum   = 11'd0;
    p_rst  = 1'b1;
    p_ov   = 1'b0;
    p_ne   = 1'b0;
    p_prod = 4'd0;
    p_sum  = 11'd0;
    e_prod = 4'd0;
    e_chg  = 11'd0;

    idle(3, 3'd0);
    p_rst = 1'b0;
    idle(2, 3'd0);

    // coin from IDLE, accepted
    step(T_COIN, 3'd2, 3'b0);
    step(5'b0, 3'd3, 3'b0);
    idle(2, 3'd0);

    // purchase of product 6; touches during dispense ignored
    p_prod = 4'd6;
    p_sum  = 11'd40;
    step(T_SEL, 3'd1, 3'b0);
    step(5'b0, 3'd1, 3'b0);
    step(T_SURE, 3'd4, 3'b0);
    e_prod = 4'd6;
    step(5'b0, 3'd5, 3'b0);
    step(5'b0, 3'd6, 3'b0);
    step(T_COIN, 3'd6, 3'b0);
    step(T_SURE, 3'd6, 3'b0);
    step(T_CHG, 3'd6, 3'b0);
    idle(4, 3'd6);
    idle(2, 3'd0);

    // not enough credit
    p_ne = 1'b1;
    step(T_SEL, 3'd1, 3'b0);
    step(T_SURE, 3'd4, 3'b0);
    step(5'b0, 3'd1, E_FAIL);
    step(5'b0, 3'd1, 3'b0);
    p_ne = 1'b0;
    // sure with no product is ignored
    p_prod = 4'd0;
    step(T_SURE, 3'd1, 3'b0);
    // coin in SELECT returns to SELECT
    step(T_COIN, 3'd2, 3'b0);
    step(5'b0, 3'd3, 3'b0);
    step(5'b0, 3'd1, 3'b0);
    // cancel wins over sure
    p_prod = 4'd3;
    step(T_CAN | T_SURE, 3'd0, 3'b0);
    idle(1, 3'd0);

    // coin overflow from SELECT and from IDLE
    p_sum = 11'd1995;
    p_ov  = 1'b1;
    step(T_SEL, 3'd1, 3'b0);
    step(T_COIN, 3'd2, 3'b0);
    step(5'b0, 3'd1, E_OV);
    step(5'b0, 3'd1, 3'b0);
    step(T_CAN, 3'd0, 3'b0);
    step(T_COIN, 3'd2, 3'b0);
    step(5'b0, 3'd0, E_OV);
    step(5'b0, 3'd0, 3'b0);
    p_ov = 1'b0;

    // refund
    p_sum = 11'd37;
    e_chg = 11'd37;
    step(T_CHG, 3'd7, 3'b0);
    step(5'b0, 3'd0, 3'b0);
    p_sum = 11'd0;
    step(T_CHG, 3'd0, 3'b0);
    step(T_CHG | T_COIN, 3'd2, 3'b0);
    step(5'b0, 3'd3, 3'b0);
    step(5'b0, 3'd0, 3'b0);

`ifdef VEND_TIMEOUT_EN
    step(T_SEL, 3'd1, 3'b0);
    idle(19, 3'd1);
    step(5'b0, 3'd0, E_TO);
    step(5'b0, 3'd0, 3'b0);
    // a touch restarts the count
    step(T_SEL, 3'd1, 3'b0);
    idle(9, 3'd1);
    step(T_SEL, 3'd1, 3'b0);
    idle(19, 3'd1);
    step(5'b0, 3'd0, E_TO);
`else
    step(T_SEL, 3'd1, 3'b0);
    idle(30, 3'd1);
    step(T_CAN, 3'd0, 3'b0);
`endif
    idle(1, 3'd0);

    // reset during PAY
    p_prod = 4'd6;
    p_sum  = 11'd50;
    step(T_SEL, 3'd1, 3'b0);
    step(T_SURE, 3'd4, 3'b0);
    p_rst  = 1'b1;
    e_prod = 4'd0;
    e_chg  = 11'd0;
    step(5'b0, 3'd0, 3'b0);
    p_rst = 1'b0;
    idle(3, 3'd0);

    // reset during DISPENSE
    step(T_SEL, 3'd1, 3'b0);
    step(T_SURE, 3'd4, 3'b0);
    e_prod = 4'd6;
    step(5'b0, 3'd5, 3'b0);
    idle(2, 3'd6);
    p_rst  = 1'b1;
    e_prod = 4'd0;
    step(5'b0, 3'd0, 3'b0);
    p_rst = 1'b0;
    idle(10, 3'd0);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_state_ctrl.md
VEND_STATE_CTRL -- requirements
Module: vend_state_ctrl

Interface
REQ-001 Parameter DISP_CYCLES, default 8: DISPENSE dwell in clocks, range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000000: SELECT inactivity limit in clocks, 32-bit counter.
REQ-003 clk  in  1  system clock; all flops on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 select_flag  in  1  level; a product key is touched while not in select state.
REQ-006 sure_flag, cancel_flag, charge_flag, coin_sig  in  1 each  one-cycle touch pulses: confirm, cancel, refund, coin key.
REQ-007 coin_ov_flag  in  1  combinational; next sum would exceed 1999, valid while coin_sta_flag=1.
REQ-008 nonenough_flag  in  1  combinational; sum is below price, valid while pay_sta_flag=1.
REQ-009 product_number  in  4  latched selection, 0 = none, 1..12 valid.
REQ-010 coin_val_sum  in  11  credit in 0.5-unit steps, 0..1999.
REQ-011 selected_sta_flag, coin_sta_flag, pay_sta_flag  out  1 each  state-phase indicators.
REQ-012 coin_fn_flag, pay_st_flag, charge_st_flag  out  1 each  one-cycle commit strobes to the touch front end.
REQ-013 coin_ov_err, pay_fail, timeout_pulse  out  1 each  one-cycle event pulses.
REQ-014 dispense_busy  out  1;  dispense_product  out  4;  charge_val  out  11;  state  out  3.

Function
REQ-015 The block SHALL be a Moore FSM; all outputs SHALL be registered or decoded from the state register only.
REQ-016 State codes SHALL be IDLE=0, SELECT=1, COIN_CHK=2, COIN_ACK=3, PAY_CHK=4, PAY_EXE=5, DISPENSE=6, CHARGE=7, and SHALL drive the state output directly.
REQ-017 IDLE SHALL transition with priority charge_flag&&coin_val_sum!=0 -> CHARGE, then coin_sig -> COIN_CHK, then select_flag -> SELECT.
REQ-018 SELECT SHALL assert selected_sta_flag and SHALL transition with priority cancel_flag -> IDLE, then sure_flag&&product_number!=0 -> PAY_CHK, then coin_sig -> COIN_CHK; sure_flag with product_number=0 SHALL be ignored.
REQ-019 On entry to COIN_CHK, the block SHALL store the return state (IDLE or SELECT).
REQ-020 COIN_CHK and COIN_ACK SHALL assert coin_sta_flag; COIN_CHK SHALL last exactly 1 cycle, and its sampled coin_ov_flag decides the next step.
REQ-021 COIN_CHK with coin_ov_flag=0 SHALL go to COIN_ACK, which SHALL assert coin_fn_flag for exactly 1 cycle and then go to the stored return state.
REQ-022 COIN_CHK with coin_ov_flag=1 SHALL pulse coin_ov_err, SHALL NOT pass through COIN_ACK, and SHALL go to the return state.
REQ-023 PAY_CHK and PAY_EXE SHALL assert pay_sta_flag.
REQ-024 PAY_CHK with nonenough_flag=1 SHALL pulse pay_fail and return to SELECT; with nonenough_flag=0 it SHALL go to PAY_EXE.
REQ-025 PAY_EXE SHALL assert pay_st_flag for exactly 1 cycle, latch dispense_product=product_number, and go to DISPENSE.
REQ-026 DISPENSE SHALL assert dispense_busy for exactly DISP_CYCLES cycles using a down-counter loaded on entry, then go to IDLE; all touch pulses SHALL be ignored during DISPENSE.
REQ-027 On entry, CHARGE SHALL latch charge_val=coin_val_sum, assert charge_st_flag for 1 cycle, and return to IDLE; charge_val SHALL hold until the next CHARGE.
REQ-028 Touch pulses arriving in COIN_*, PAY_*, or CHARGE SHALL be dropped, not queued.
REQ-029 At most one of selected_sta_flag, coin_sta_flag, pay_sta_flag SHALL be high in any cycle.

Reset
REQ-030 While rst=1, the block SHALL set state=IDLE and clear all flags, pulses, dispense_busy, dispense_product, charge_val, and all counters and the return register to 0 at the next edge.
REQ-031 Reset asserted mid-DISPENSE or mid-PAY SHALL abort the transaction with no further strobes.

Configuration
REQ-032 Macro VEND_TIMEOUT_EN defined: in SELECT, a counter SHALL reset on any select_flag, sure_flag, cancel_flag, or coin_sig; on reaching TIMEOUT_CYCLES the block SHALL pulse timeout_pulse and go to IDLE.
REQ-033 Macro VEND_TIMEOUT_EN undefined: no counter SHALL be built, timeout_pulse SHALL be tied to 0, and SELECT SHALL wait indefinitely.

Verification
REQ-034 Reset, then coin_sig in IDLE with coin_ov_flag=0 -> state 0->2->3->0, with coin_fn_flag high exactly 1 cycle, 2 cycles after coin_sig.
REQ-035 select_flag, then sure_flag with product_number=6 and nonenough_flag=0 -> PAY_CHK, PAY_EXE (pay_st_flag 1 cycle), dispense_product=6, dispense_busy high 8 cycles, then IDLE.
REQ-036 In SELECT, sure_flag with nonenough_flag=1 -> pay_fail 1 cycle, state back to 1, with pay_st_flag never high.
REQ-037 coin_val_sum=1995 and coin_sig with coin_ov_flag=1 -> coin_ov_err 1 cycle, with no coin_fn_flag, and return to the prior state.
REQ-038 IDLE with coin_val_sum=37 and charge_flag -> charge_val=37 and charge_st_flag 1 cycle; charge_flag with sum=0 -> state stays 0.
REQ-039 With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=20, enter SELECT and idle 20 cycles -> timeout_pulse, then IDLE; cancel_flag and sure_flag in the same cycle -> IDLE.
